dafx_axi_cfg_slave: RTL and testbench

DAFX_AXI_CFG_SLAVE -- requirements
Module: dafx_axi_cfg_slave

---
 rtl/dafx_axi_cfg_slave.sv | 193 +++++++++++++++++++
 tb/tb_dafx_axi_cfg_slave.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dafx_axi_cfg_slave.sv
// AXI-Lite configuration/status register slave for the DAFX mixer and oscillator bank.
// Define DAFX_AXI_WSTRB_EN to honour wstrb byte lanes; otherwise every write is a full word.
module dafx_axi_cfg_slave #(
  parameter int          AXI_ADDR_WIDTH_P = 16,
  parameter int          AXI_DATA_WIDTH_P = 32,
  parameter int          NR_OF_CH_P       = 4,
  parameter int          GAIN_WIDTH_P     = 16,
  parameter int          N_BITS_P         = 32,
  parameter int          AUDIO_WIDTH_P    = 24,
  parameter logic [31:0] HW_VERSION_P     = 32'h0000_0200
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [AXI_ADDR_WIDTH_P-1:0]          awaddr,
  input  logic                                 awvalid,
  output logic                                 awready,
  input  logic [AXI_DATA_WIDTH_P-1:0]          wdata,
  input  logic [3:0]                           wstrb,
  input  logic                                 wvalid,
  output logic                                 wready,
  output logic [1:0]                           bresp,
  output logic                                 bvalid,
  input  logic                                 bready,
  input  logic [AXI_ADDR_WIDTH_P-1:0]          araddr,
  input  logic                                 arvalid,
  output logic                                 arready,
  output logic [AXI_DATA_WIDTH_P-1:0]          rdata,
  output logic [1:0]                           rresp,
  output logic                                 rvalid,
  input  logic                                 rready,
  output logic [GAIN_WIDTH_P-1:0]              cr_mix_output_gain,
  output logic [NR_OF_CH_P*GAIN_WIDTH_P-1:0]   cr_ch_gain,
  output logic [NR_OF_CH_P*2-1:0]              cr_osc_waveform,
  output logic [NR_OF_CH_P*N_BITS_P-1:0]       cr_osc_frequency,
  output logic [NR_OF_CH_P*N_BITS_P-1:0]       cr_osc_duty,
  input  logic [AUDIO_WIDTH_P-1:0]             sr_mix_out_left,
  input  logic [AUDIO_WIDTH_P-1:0]             sr_mix_out_right,
  input  logic [NR_OF_CH_P-1:0]                irq_event,
  output logic                                 cmd_clear_amplitude,
  output logic                                 irq
);
  localparam int AW = AXI_ADDR_WIDTH_P;
  localparam int NR = NR_OF_CH_P;
  localparam int G  = GAIN_WIDTH_P;
  localparam int NB = N_BITS_P;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    for (int k = 0; k < 4; k++)
      merge[8*k +: 8] = strb[k] ? nw[8*k +: 8] : old[8*k +: 8];
  endfunction

  logic            aw_full, w_full, do_wr, wr_ok, rd_ok;
  logic [AW-1:2]   aw_word;
  logic [31:0]     w_data, wa, ra, rd_val, clr_bits;
  logic [3:0]      w_strb;
  logic [NR-1:0]   irq_status, irq_enable, irq_clr, status_nxt;
  logic [G-1:0]    gain_out;
  logic [G-1:0]    ch_gain  [NR];
  logic [1:0]      osc_wave [NR];
  logic [NB-1:0]   osc_freq [NR];
  logic [NB-1:0]   osc_duty [NR];
  logic            unused_bits;

`ifdef DAFX_AXI_WSTRB_EN
  assign unused_bits = ^{awaddr[1:0], araddr[1:0]};
`else
  assign w_strb      = 4'hF;
  assign unused_bits = ^{awaddr[1:0], araddr[1:0], wstrb};
`endif

  assign awready  = !aw_full;
  assign wready   = !w_full;
  assign arready  = !rvalid || rready;
  assign do_wr    = aw_full && w_full && (!bvalid || bready);
  assign wa       = 32'({aw_word, 2'b00});
  assign ra       = 32'({araddr[AW-1:2], 2'b00});
  assign clr_bits = merge(32'h0, w_data, w_strb);
  assign irq_clr  = (do_wr && wa == 32'h008) ? NR'(clr_bits) : '0;
  // Event set is OR-ed in after the clear so a coincident event survives.
  assign status_nxt = (irq_status & ~irq_clr) | irq_event;

  always_comb begin
    wr_ok = (wa == 32'h004) || (wa == 32'h008) || (wa == 32'h00C) || (wa == 32'h010);
    for (int n = 0; n < NR; n++) begin
      if (wa == 32'h100 + 32'(4*n)) wr_ok = 1'b1;
      if (wa == 32'h200 + 32'(16*n) || wa == 32'h204 + 32'(16*n) || wa == 32'h208 + 32'(16*n))
        wr_ok = 1'b1;
    end
  end

  always_comb begin
    rd_ok  = 1'b1;
    rd_val = 32'h0;
    case (ra)
      32'h000: rd_val = HW_VERSION_P;
      32'h004: rd_val = 32'(gain_out);
      32'h008: rd_val = 32'(irq_status);
      32'h00C: rd_val = 32'(irq_enable);
      32'h014: rd_val = 32'(sr_mix_out_left);
      32'h018: rd_val = 32'(sr_mix_out_right);
      default: rd_ok  = 1'b0;
    endcase
    for (int n = 0; n < NR; n++) begin
      if (ra == 32'h100 + 32'(4*n))  begin rd_ok = 1'b1; rd_val = 32'(ch_gain[n]);  end
      if (ra == 32'h200 + 32'(16*n)) begin rd_ok = 1'b1; rd_val = 32'(osc_wave[n]); end
      if (ra == 32'h204 + 32'(16*n)) begin rd_ok = 1'b1; rd_val = 32'(osc_freq[n]); end
      if (ra == 32'h208 + 32'(16*n)) begin rd_ok = 1'b1; rd_val = 32'(osc_duty[n]); end
    end
    if (!rd_ok) rd_val = 32'hBAAD_FACE;
  end

  // Holder payloads carry no reset; the full flags alone qualify them.
  always_ff @(posedge clk) begin
    if (awvalid && !aw_full) aw_word <= awaddr[AW-1:2];
    if (wvalid && !w_full) begin
      w_data <= wdata;
`ifdef DAFX_AXI_WSTRB_EN
      w_strb <= wstrb;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full             <= 1'b0;
      w_full              <= 1'b0;
      bvalid              <= 1'b0;
      bresp               <= 2'b00;
      rvalid              <= 1'b0;
      rresp               <= 2'b00;
      rdata               <= '0;
      irq_status          <= '0;
      irq                 <= 1'b0;
      cmd_clear_amplitude <= 1'b0;
    end else begin
      if (do_wr)                    aw_full <= 1'b0;
      else if (awvalid && !aw_full) aw_full <= 1'b1;
      if (do_wr)                    w_full  <= 1'b0;
      else if (wvalid && !w_full)   w_full  <= 1'b1;
      if (do_wr) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? 2'b00 : 2'b10;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
        rresp  <= rd_ok ? 2'b00 : 2'b10;
      end else if (rready) begin
        rvalid <= 1'b0;
      end
      irq_status          <= status_nxt;
      irq                 <= |(irq_status & irq_enable);
      cmd_clear_amplitude <= do_wr && (wa == 32'h010) && clr_bits[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_out   <= G'(1);
      irq_enable <= '0;
      for (int n = 0; n < NR; n++) begin
        ch_gain[n]  <= G'(1);
        osc_wave[n] <= 2'b00;
        osc_freq[n] <= NB'(500);
        osc_duty[n] <= NB'(500);
      end
    end else if (do_wr && wr_ok) begin
      if (wa == 32'h004) gain_out   <= G'(merge(32'(gain_out), w_data, w_strb));
      if (wa == 32'h00C) irq_enable <= NR'(merge(32'(irq_enable), w_data, w_strb));
      for (int n = 0; n < NR; n++) begin
        if (wa == 32'h100 + 32'(4*n))
          ch_gain[n]  <= G'(merge(32'(ch_gain[n]), w_data, w_strb));
        if (wa == 32'h200 + 32'(16*n))
          osc_wave[n] <= 2'(merge(32'(osc_wave[n]), w_data, w_strb));
        if (wa == 32'h204 + 32'(16*n))
          osc_freq[n] <= NB'(merge(32'(osc_freq[n]), w_data, w_strb));
        if (wa == 32'h208 + 32'(16*n))
          osc_duty[n] <= NB'(merge(32'(osc_duty[n]), w_data, w_strb));
      end
    end
  end

  assign cr_mix_output_gain = gain_out;
  for (genvar n = 0; n < NR; n++) begin : g_pack
    assign cr_ch_gain[n*G +: G]        = ch_gain[n];
    assign cr_osc_waveform[n*2 +: 2]   = osc_wave[n];
    assign cr_osc_frequency[n*NB +: NB] = osc_freq[n];
    assign cr_osc_duty[n*NB +: NB]     = osc_duty[n];
  end
endmodule

// File: tb/tb_dafx_axi_cfg_slave.sv
// Bench for dafx_axi_cfg_slave: directed scenarios plus random register traffic
// checked against a register-map reference model.
module tb_dafx_axi_cfg_slave;
  localparam int AW = 16, NR = 4, G = 16, NB = 32, AUD = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    awaddr = '0, araddr = '0;
  logic             awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
  logic [31:0]      wdata = '0;
  logic [3:0]       wstrb = 4'hF;
  logic             awready, wready, bvalid, arready, rvalid, cmd_clear_amplitude, irq;
  logic [1:0]       bresp, rresp;
  logic [31:0]      rdata;
  logic [G-1:0]     cr_mix_output_gain;
  logic [NR*G-1:0]  cr_ch_gain;
  logic [NR*2-1:0]  cr_osc_waveform;
  logic [NR*NB-1:0] cr_osc_frequency, cr_osc_duty;
  logic [AUD-1:0]   sr_l = '0, sr_r = '0;
  logic [NR-1:0]    irq_event = '0;

  dafx_axi_cfg_slave #(
    .AXI_ADDR_WIDTH_P(AW), .AXI_DATA_WIDTH_P(32), .NR_OF_CH_P(NR), .GAIN_WIDTH_P(G),
    .N_BITS_P(NB), .AUDIO_WIDTH_P(AUD), .HW_VERSION_P(32'h0000_0200)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .cr_mix_output_gain(cr_mix_output_gain), .cr_ch_gain(cr_ch_gain),
    .cr_osc_waveform(cr_osc_waveform), .cr_osc_frequency(cr_osc_frequency),
    .cr_osc_duty(cr_osc_duty), .sr_mix_out_left(sr_l), .sr_mix_out_right(sr_r),
    .irq_event(irq_event), .cmd_clear_amplitude(cmd_clear_amplitude), .irq(irq)
  );

  int total = 0, bad = 0;
  int pulse_cnt = 0;
  always @(negedge clk) if (cmd_clear_amplitude === 1'b1) pulse_cnt++;

  // Reference model: register contents as plain integers
  logic [31:0] m_gain, m_en, m_status;
  logic [31:0] m_ch [NR], m_wave [NR], m_freq [NR], m_duty [NR];

  task automatic model_reset();
    m_gain = 1; m_en = 0; m_status = 0;
    for (int i = 0; i < NR; i++) begin
      m_ch[i] = 1; m_wave[i] = 0; m_freq[i] = 500; m_duty[i] = 500;
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
`ifdef DAFX_AXI_WSTRB_EN
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (nw & m) | (old & ~m);
`else
    return (s == 4'h0 || s != 4'h0) ? nw : old;
`endif
  endfunction

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int a;
    a = int'(addr & 32'hFFFF_FFFC);
    r = 2'b00;
    if (a == 0) d = 32'h0000_0200;
    else if (a == 4)  d = m_gain;
    else if (a == 8)  d = m_status;
    else if (a == 12) d = m_en;
    else if (a == 20) d = 32'(sr_l);
    else if (a == 24) d = 32'(sr_r);
    else if (a >= 256 && a < 256 + 4*NR) d = m_ch[(a-256)/4];
    else if (a >= 512 && a < 512 + 16*NR && (a % 16) < 12) begin
      case ((a % 16) / 4)
        0:       d = m_wave[(a-512)/16];
        1:       d = m_freq[(a-512)/16];
        default: d = m_duty[(a-512)/16];
      endcase
    end else begin
      d = 32'hBAAD_FACE; r = 2'b10;
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    int a, i;
    a = int'(addr & 32'hFFFF_FFFC);
    r = 2'b00;
    if (a == 4)       m_gain = lanes(m_gain, d, s) & 32'hFFFF;
    else if (a == 8)  m_status = m_status & ~lanes(32'h0, d, s);
    else if (a == 12) m_en = lanes(m_en, d, s) & 32'hF;
    else if (a == 16) r = 2'b00;
    else if (a >= 256 && a < 256 + 4*NR) begin
      i = (a-256)/4; m_ch[i] = lanes(m_ch[i], d, s) & 32'hFFFF;
    end else if (a >= 512 && a < 512 + 16*NR && (a % 16) < 12) begin
      i = (a-512)/16;
      case ((a % 16) / 4)
        0:       m_wave[i] = lanes(m_wave[i], d, s) & 32'h3;
        1:       m_freq[i] = lanes(m_freq[i], d, s);
        default: m_duty[i] = lanes(m_duty[i], d, s);
      endcase
    end else r = 2'b10;
  endtask

  // Bus tasks: drive and sample on the falling edge
  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
    int cyc;
    logic aw_hs, w_hs;
    @(negedge clk);
    awaddr = addr[AW-1:0]; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    cyc = 0;
    while ((awvalid || wvalid) && cyc < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      if (aw_hs) awvalid = 0;
      if (w_hs)  wvalid = 0;
      cyc++;
    end
    total++;
    if (awvalid || wvalid) begin
      bad++; $display("FAIL aw_w_timeout addr=%h awvalid=%b wvalid=%b exp both 0", addr, awvalid, wvalid);
      awvalid = 0; wvalid = 0;
    end
  endtask

  task automatic wait_b(output logic [1:0] r, output logic c);
    int cyc;
    cyc = 0;
    while (!bvalid && cyc < 50) begin @(negedge clk); cyc++; end
    total++;
    if (!bvalid) begin bad++; $display("FAIL b_timeout bvalid=%b exp 1", bvalid); end
    r = bresp; c = cmd_clear_amplitude;
    @(negedge clk);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r, output logic c);
    send_aw_w(addr, d, s);
    wait_b(r, c);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int cyc;
    @(negedge clk);
    araddr = addr[AW-1:0]; arvalid = 1;
    cyc = 0;
    while (!arready && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    arvalid = 0;
    cyc = 0;
    while (!rvalid && cyc < 50) begin @(negedge clk); cyc++; end
    total++;
    if (!rvalid) begin bad++; $display("FAIL r_timeout addr=%h rvalid=%b exp 1", addr, rvalid); end
    d = rdata; r = rresp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if ({awready, wready, arready, bvalid, rvalid, irq, cmd_clear_amplitude} !== 7'b1110000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=1110000",
                      {awready, wready, arready, bvalid, rvalid, irq, cmd_clear_amplitude});
    end
    total++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      bad++; $display("FAIL reset_resp got=%h exp=0", {bresp, rresp, rdata});
    end
    total++;
    if (cr_mix_output_gain !== 16'd1) begin
      bad++; $display("FAIL reset_gain got=%h exp=1", cr_mix_output_gain);
    end
    for (int i = 0; i < NR; i++) begin
      total++;
      if (cr_ch_gain[i*G +: G] !== 16'd1 || cr_osc_waveform[i*2 +: 2] !== 2'd0 ||
          cr_osc_frequency[i*NB +: NB] !== 32'd500 || cr_osc_duty[i*NB +: NB] !== 32'd500) begin
        bad++; $display("FAIL reset_ch%0d got g=%h w=%h f=%0d d=%0d exp 1/0/500/500", i,
                        cr_ch_gain[i*G +: G], cr_osc_waveform[i*2 +: 2],
                        cr_osc_frequency[i*NB +: NB], cr_osc_duty[i*NB +: NB]);
      end
    end
  endtask

  task automatic test_w_before_aw();
    int nb;
    logic [1:0] r, mr;
    @(negedge clk);
    wdata = 32'h1234; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    total++;
    if (wready !== 1'b0) begin bad++; $display("FAIL w_hold_wready got=%b exp=0", wready); end
    repeat (2) @(negedge clk);
    awaddr = 16'h0100; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    nb = 0; r = 2'b11;
    repeat (8) begin
      if (bvalid) begin nb++; r = bresp; end
      @(negedge clk);
    end
    model_write(32'h100, 32'h1234, 4'hF, mr);
    total++;
    if (nb != 1 || r !== 2'b00) begin
      bad++; $display("FAIL w_first_b got count=%0d bresp=%b exp count=1 bresp=00", nb, r);
    end
    total++;
    if (cr_ch_gain[15:0] !== 16'h1234) begin
      bad++; $display("FAIL w_first_gain got=%h exp=1234", cr_ch_gain[15:0]);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [1:0]  r;
    logic        c;
    logic [31:0] ua [4] = '{32'h0FC, 32'h010, 32'h100 + 4*NR, 32'h20C};
    for (int i = 0; i < 4; i++) begin
      axi_read(ua[i], d, r);
      total++;
      if (d !== 32'hBAAD_FACE || r !== 2'b10) begin
        bad++; $display("FAIL unmapped_rd addr=%h got %h/%b exp BAADFACE/10", ua[i], d, r);
      end
    end
    axi_write(32'h000, 32'hFFFF_FFFF, 4'hF, r, c);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL ro_wr_resp got=%b exp=10", r); end
    axi_write(32'h200 + 16*NR, 32'h3, 4'hF, r, c);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL osc_oob_resp got=%b exp=10", r); end
    axi_read(32'h000, d, r);
    total++;
    if (d !== 32'h0000_0200 || r !== 2'b00) begin
      bad++; $display("FAIL version got %h/%b exp 00000200/00", d, r);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [1:0]  r, mr;
    logic        c;
    axi_write(32'h00C, 32'h1, 4'hF, r, c); model_write(32'h00C, 32'h1, 4'hF, mr);
    // event coincident with a W1C of the same bit
    @(negedge clk);
    awaddr = 16'h0008; awvalid = 1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; irq_event = 4'b0001;
    @(negedge clk);
    irq_event = 4'b0000;
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      bad++; $display("FAIL irq_w1c_b got bvalid=%b bresp=%b exp 1/00", bvalid, bresp);
    end
    model_write(32'h008, 32'h1, 4'hF, mr); m_status = m_status | 32'h1;
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins got=%b exp=1", irq); end
    axi_read(32'h008, d, r);
    total++;
    if (d !== m_status) begin bad++; $display("FAIL irq_status_rd got=%h exp=%h", d, m_status); end
    axi_write(32'h008, 32'h1, 4'hF, r, c); model_write(32'h008, 32'h1, 4'hF, mr);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
    // masked event, then enable it
    @(negedge clk); irq_event = 4'b0010;
    @(negedge clk); irq_event = 4'b0000; m_status = m_status | 32'h2;
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", irq); end
    axi_write(32'h00C, 32'h3, 4'hF, r, c); model_write(32'h00C, 32'h3, 4'hF, mr);
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_enable got=%b exp=1", irq); end
    axi_write(32'h008, 32'h2, 4'hF, r, c); model_write(32'h008, 32'h2, 4'hF, mr);
    @(negedge clk);
    total++;
    if (irq !== 1'b0 || m_status !== 32'h0) begin
      bad++; $display("FAIL irq_final got=%b exp=0", irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] q[$];
    logic [1:0] mr;
    logic [15:0] old_g;
    int cyc;
    old_g = m_ch[0][15:0];
    bready = 0;
    send_aw_w(32'h000, 32'hDEAD, 4'hF);
    cyc = 0;
    while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    send_aw_w(32'h100, 32'h55, 4'hF);
    repeat (8) @(negedge clk);
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0 || wready !== 1'b0) begin
      bad++; $display("FAIL stall_state got bvalid=%b bresp=%b awready=%b wready=%b exp 1/10/0/0",
                      bvalid, bresp, awready, wready);
    end
    total++;
    if (cr_ch_gain[15:0] !== old_g) begin
      bad++; $display("FAIL stall_no_exec got=%h exp=%h", cr_ch_gain[15:0], old_g);
    end
    bready = 1;
    repeat (6) begin
      if (bvalid) q.push_back(bresp);
      @(negedge clk);
    end
    model_write(32'h000, 32'hDEAD, 4'hF, mr);
    model_write(32'h100, 32'h55, 4'hF, mr);
    total++;
    if (q.size() != 2) begin
      bad++; $display("FAIL b2b_count got=%0d exp=2", q.size());
    end else if (q[0] !== 2'b10 || q[1] !== 2'b00) begin
      bad++; $display("FAIL b2b_order got=%b,%b exp=10,00", q[0], q[1]);
    end
    total++;
    if (cr_ch_gain[15:0] !== 16'h0055) begin
      bad++; $display("FAIL b2b_exec got=%h exp=0055", cr_ch_gain[15:0]);
    end
  endtask

  task automatic test_clear_amplitude();
    logic [1:0] r;
    logic       c;
    int         p0;
    p0 = pulse_cnt;
    axi_write(32'h010, 32'h1, 4'hF, r, c);
    repeat (3) @(negedge clk);
    total++;
    if (c !== 1'b1 || r !== 2'b00 || pulse_cnt - p0 != 1) begin
      bad++; $display("FAIL clr_amp_pulse got cmd=%b resp=%b pulses=%0d exp 1/00/1", c, r, pulse_cnt - p0);
    end
    p0 = pulse_cnt;
    axi_write(32'h010, 32'hFFFF_FFFE, 4'hF, r, c);
    repeat (3) @(negedge clk);
    total++;
    if (c !== 1'b0 || pulse_cnt - p0 != 0) begin
      bad++; $display("FAIL clr_amp_zero got cmd=%b pulses=%0d exp 0/0", c, pulse_cnt - p0);
    end
  endtask

  task automatic test_strobe();
    logic [1:0]  r, mr;
    logic        c;
    logic [31:0] exp_f;
`ifdef DAFX_AXI_WSTRB_EN
    exp_f = 32'h0000_CCF4;
`else
    exp_f = 32'hAABB_CCDD;
`endif
    axi_write(32'h204, 32'hAABB_CCDD, 4'b0010, r, c);
    model_write(32'h204, 32'hAABB_CCDD, 4'b0010, mr);
    total++;
    if (cr_osc_frequency[31:0] !== exp_f || r !== 2'b00) begin
      bad++; $display("FAIL strobe_freq got=%h resp=%b exp=%h/00", cr_osc_frequency[31:0], r, exp_f);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [16] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014, 32'h018,
                               32'h01C, 32'h100, 32'h10C, 32'h110, 32'h200, 32'h214, 32'h238,
                               32'h23C, 32'h240};
    logic [31:0] addr, d, ed;
    logic [3:0]  s;
    logic [1:0]  r, er;
    logic        c;
    sr_l = AUD'($urandom); sr_r = AUD'($urandom);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) addr = $urandom_range(0, 32'h2FF);
      else addr = pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        axi_write(addr, d, s, r, c);
        model_write(addr, d, s, er);
        total++;
        if (r !== er) begin bad++; $display("FAIL rnd_wr addr=%h got=%b exp=%b", addr, r, er); end
      end else begin
        axi_read(addr, d, r);
        model_read(addr, ed, er);
        total++;
        if (d !== ed || r !== er) begin
          bad++; $display("FAIL rnd_rd addr=%h got %h/%b exp %h/%b", addr, d, r, ed, er);
        end
      end
    end
    total++;
    if (32'(cr_mix_output_gain) !== m_gain || irq !== |(m_status & m_en)) begin
      bad++; $display("FAIL rnd_gain_irq got %h/%b exp %h/%b", cr_mix_output_gain, irq,
                      m_gain, |(m_status & m_en));
    end
    for (int i = 0; i < NR; i++) begin
      total++;
      if (32'(cr_ch_gain[i*G +: G]) !== m_ch[i] || 32'(cr_osc_waveform[i*2 +: 2]) !== m_wave[i] ||
          cr_osc_frequency[i*NB +: NB] !== m_freq[i] || cr_osc_duty[i*NB +: NB] !== m_duty[i]) begin
        bad++; $display("FAIL rnd_ports ch%0d got %h/%h/%h/%h exp %h/%h/%h/%h", i,
                        cr_ch_gain[i*G +: G], cr_osc_waveform[i*2 +: 2], cr_osc_frequency[i*NB +: NB],
                        cr_osc_duty[i*NB +: NB], m_ch[i], m_wave[i], m_freq[i], m_duty[i]);
      end
    end
  endtask

  task automatic test_reset_midread();
    logic [31:0] d;
    logic [1:0]  r, mr;
    logic        c;
    axi_write(32'h004, 32'h99, 4'hF, r, c); model_write(32'h004, 32'h99, 4'hF, mr);
    rready = 0;
    @(negedge clk);
    araddr = 16'h0004; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    @(negedge clk);
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'h99) begin
      bad++; $display("FAIL rd_pending got rvalid=%b rdata=%h exp 1/00000099", rvalid, rdata);
    end
    rst_n = 0;
    #1;
    total++;
    if (rvalid !== 1'b0 || cr_mix_output_gain !== 16'd1 || cr_osc_frequency[NB-1:0] !== 32'd500) begin
      bad++; $display("FAIL mid_reset got rvalid=%b gain=%h freq=%0d exp 0/1/500",
                      rvalid, cr_mix_output_gain, cr_osc_frequency[NB-1:0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1; rready = 1;
    model_reset();
    axi_read(32'h004, d, r);
    total++;
    if (d !== 32'h1 || r !== 2'b00) begin
      bad++; $display("FAIL post_reset_rd got %h/%b exp 00000001/00", d, r);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_w_before_aw();
    test_unmapped();
    test_irq();
    test_back_to_back();
    test_clear_amplitude();
    test_strobe();
    test_random();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
